dff_reg_arbiter: RTL and testbench



---
 rtl/dff_reg_arbiter_pkg.sv | 17 +
 rtl/dff_reg_arbiter_if.sv | 42 ++++
 rtl/dff_reg_arbiter_cell.sv | 27 ++
 rtl/dff_reg_arbiter.sv | 140 ++++++++++++++
 tb/tb_dff_reg_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/dff_reg_arbiter_pkg.sv
// rtl/dff_reg_arbiter_pkg.sv - shared op codes and FSM state encodings for dff_reg_arbiter
package dff_reg_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_LOAD   = 2'b01,
        OP_PRESET = 2'b10,
        OP_CLEAR  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

endpackage

// File: rtl/dff_reg_arbiter_if.sv
// rtl/dff_reg_arbiter_if.sv - requester-side bus of the shared-register arbiter
//
// Signals:
//   req[N_REQ]            per-requester request level
//   op[2*N_REQ]           per-requester op, requester i in [2i+1:2i]
//   wdata[WIDTH*N_REQ]    per-requester load data, requester i in slice i
//   gnt[N_REQ]            one-hot grant, one cycle per service
//   busy                  arbiter not idle
//   q[WIDTH]              shared register contents
//   owner, owner_vld      last modifier of q (only with DFF_ARB_OWNER_EN)
// Modports: master (requesters), slave (arbiter).
interface dff_reg_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [2*N_REQ-1:0]     op;
    logic [WIDTH*N_REQ-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic [WIDTH-1:0]       q;
`ifdef DFF_ARB_OWNER_EN
    logic [$clog2(N_REQ)-1:0] owner;
    logic                     owner_vld;
`endif

    modport master (
        output req, op, wdata,
`ifdef DFF_ARB_OWNER_EN
        input  owner, owner_vld,
`endif
        input  gnt, busy, q
    );

    modport slave (
        input  req, op, wdata,
`ifdef DFF_ARB_OWNER_EN
        output owner, owner_vld,
`endif
        output gnt, busy, q
    );
endinterface

// File: rtl/dff_reg_arbiter_cell.sv
// rtl/dff_reg_arbiter_cell.sv - dff_pc_cell: WIDTH-bit register with synchronous load/set/clear
//
// Ports: clk, rst_n (async active-low), en (load d), set (all ones),
//        clr (all zeros), d[WIDTH], q[WIDTH]. Precedence clr > set > en.
module dff_pc_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             set,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (set) begin
            q <= '1;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/dff_reg_arbiter.sv
// rtl/dff_reg_arbiter.sv - round-robin arbiter sharing one dff_pc_cell register among N_REQ requesters
//
// Ports: clk, rst_n (async active-low), bus (dff_reg_arbiter_if.slave:
//        req/op/wdata in, gnt/busy/q out).
// Optional macro DFF_ARB_OWNER_EN adds bus.owner / bus.owner_vld tracking
// the requester that last modified q.
module dff_reg_arbiter
    import dff_reg_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    dff_reg_arbiter_if.slave   bus
);
    localparam int IW = $clog2(N_REQ);

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    sel;
    logic [WIDTH-1:0] cap_data;
    logic             cell_en, cell_set, cell_clr;
    logic [N_REQ-1:0] gnt_r;
    logic             busy_r;
    logic [WIDTH-1:0] q_int;

    op_t              op_arr   [N_REQ];
    logic [WIDTH-1:0] data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_split
        assign op_arr[g]   = op_t'(bus.op[2*g +: 2]);
        assign data_arr[g] = bus.wdata[WIDTH*g +: WIDTH];
    end

    // Winner: first asserted req searching upward from ptr, wrapping at N_REQ.
    logic          any;
    logic [IW-1:0] win;
    logic [IW:0]   cand;

    always_comb begin
        any  = 1'b0;
        win  = '0;
        cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (!any && bus.req[cand[IW-1:0]]) begin
                any = 1'b1;
                win = cand[IW-1:0];
            end
        end
    end

`ifdef DFF_ARB_OWNER_EN
    logic [IW-1:0] owner_r;
    logic          owner_vld_r;
    op_t           cap_op;
`endif

    // Cell controls are registered at IDLE->EXEC so the cell updates on the
    // edge leaving EXEC, the same edge that drops gnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            sel      <= '0;
            cap_data <= '0;
            cell_en  <= 1'b0;
            cell_set <= 1'b0;
            cell_clr <= 1'b0;
            gnt_r    <= '0;
            busy_r   <= 1'b0;
`ifdef DFF_ARB_OWNER_EN
            cap_op      <= OP_NOP;
            owner_r     <= '0;
            owner_vld_r <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        sel      <= win;
                        cap_data <= data_arr[win];
                        cell_en  <= (op_arr[win] == OP_LOAD);
                        cell_set <= (op_arr[win] == OP_PRESET);
                        cell_clr <= (op_arr[win] == OP_CLEAR);
                        gnt_r    <= N_REQ'(1) << win;
                        busy_r   <= 1'b1;
`ifdef DFF_ARB_OWNER_EN
                        cap_op   <= op_arr[win];
`endif
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    gnt_r    <= '0;
                    cell_en  <= 1'b0;
                    cell_set <= 1'b0;
                    cell_clr <= 1'b0;
`ifdef DFF_ARB_OWNER_EN
                    if (cap_op != OP_NOP) begin
                        owner_r     <= sel;
                        owner_vld_r <= 1'b1;
                    end
`endif
                    state    <= ST_GAP;
                end
                ST_GAP: begin
                    ptr    <= (sel == IW'(N_REQ-1)) ? '0 : sel + 1'b1;
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    dff_pc_cell #(.WIDTH(WIDTH)) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cell_en),
        .set   (cell_set),
        .clr   (cell_clr),
        .d     (cap_data),
        .q     (q_int)
    );

    assign bus.gnt  = gnt_r;
    assign bus.busy = busy_r;
    assign bus.q    = q_int;
`ifdef DFF_ARB_OWNER_EN
    assign bus.owner     = owner_r;
    assign bus.owner_vld = owner_vld_r;
`endif
endmodule

// File: tb/tb_dff_reg_arbiter.sv
// tb/tb_dff_reg_arbiter.sv - self-checking bench for dff_reg_arbiter
module tb_dff_reg_arbiter;
    localparam int N_REQ = 4;
    localparam int WIDTH = 8;

    localparam logic [1:0] NOP = 2'b00, LD = 2'b01, PRE = 2'b10, CLR = 2'b11;

    logic clk;
    logic rst_n;

    dff_reg_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

    dff_reg_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] q;
        logic [1:0] own;
        logic       own_vld;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    bit   q_pending = 0;
    bit   mon_en    = 1;

    logic [1:0] own_m;
    logic       own_vld_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input logic [3:0] g, input logic [7:0] qv,
                                     input int idx, input logic [1:0] opc);
        exp_t e;
        if (opc != NOP) begin
            own_m     = 2'(idx);
            own_vld_m = 1'b1;
        end
        e.gnt = g; e.q = qv; e.own = own_m; e.own_vld = own_vld_m;
        sb.push_back(e);
    endfunction

    // Scoreboard monitor: gnt checked when seen, q/owner one cycle later.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (q_pending) begin
                check("q", bus.q, pend.q);
`ifdef DFF_ARB_OWNER_EN
                check("owner", bus.owner, pend.own);
                check("owner_vld", bus.owner_vld, pend.own_vld);
`endif
                q_pending = 0;
            end
            if (bus.gnt != 0) begin
                if (sb.size() == 0) begin
                    check("unexpected_gnt", bus.gnt, 0);
                end else begin
                    pend = sb.pop_front();
                    check("gnt", bus.gnt, pend.gnt);
                    q_pending = 1;
                end
            end
        end
    end

    task automatic wait_gnt(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (bus.gnt == 0 && cycles < 20);
        check("gnt_seen", bus.gnt != 0, 1);
    endtask

    task automatic apply(input int idx, input logic [1:0] opc, input logic [7:0] d);
        bus.req   = 4'(1) << idx;
        bus.op    = 8'(opc) << (2*idx);
        bus.wdata = 32'(d) << (8*idx);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0; bus.op = '0; bus.wdata = '0;
        own_m = '0; own_vld_m = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", bus.gnt, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_q", bus.q, 0);
`ifdef DFF_ARB_OWNER_EN
        check("rst_owner", bus.owner, 0);
        check("rst_owner_vld", bus.owner_vld, 0);
`endif
        rst_n = 1'b1;
    endtask

    // One isolated service; optionally rewrites wdata while in EXEC.
    task automatic run_one(input int idx, input logic [1:0] opc, input logic [7:0] d,
                           input logic [3:0] eg, input logic [7:0] eq,
                           input bit chg, input logic [7:0] chg_d);
        int c;
        apply(idx, opc, d);
        push_exp(eg, eq, idx, opc);
        wait_gnt(c);
        check("latency", c, 1);
        check("busy_exec", bus.busy, 1);
        if (chg) bus.wdata = 32'(chg_d) << (8*idx);
        bus.req = '0;
        @(negedge clk);
        check("busy_gap", bus.busy, 1);
        check("gnt_gap", bus.gnt, 0);
        @(negedge clk);
        check("busy_idle", bus.busy, 0);
    endtask

    typedef struct {
        int         idx;
        logic [1:0] opc;
        logic [7:0] d;
        logic [3:0] eg;
        logic [7:0] eq;
    } vec_t;

    vec_t vt[6];

    initial begin
        int c;
        vt[0] = '{0, LD,  8'hA5, 4'b0001, 8'hA5};
        vt[1] = '{2, PRE, 8'h00, 4'b0100, 8'hFF};
        vt[2] = '{3, CLR, 8'h12, 4'b1000, 8'h00};
        vt[3] = '{1, NOP, 8'h77, 4'b0010, 8'h00};
        vt[4] = '{3, LD,  8'h3C, 4'b1000, 8'h3C};
        vt[5] = '{1, NOP, 8'hEE, 4'b0010, 8'h3C};

        do_reset();
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_one(vt[i].idx, vt[i].opc, vt[i].d, vt[i].eg, vt[i].eq, 1'b0, 8'h00);

        // wdata changed during EXEC must be ignored
        run_one(0, LD, 8'h55, 4'b0001, 8'h55, 1'b1, 8'hAA);

        // all requesters held: round-robin from ptr=0, three cycles apart
        do_reset();
        @(negedge clk);
        bus.req   = 4'b1111;
        bus.op    = 8'b01010101;
        bus.wdata = {8'd4, 8'd3, 8'd2, 8'd1};
        for (int k = 0; k < 5; k++)
            push_exp(4'(1) << (k % 4), 8'((k % 4) + 1), k % 4, LD);
        for (int k = 0; k < 5; k++) begin
            wait_gnt(c);
            check("rr_spacing", c, (k == 0) ? 1 : 3);
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
        check("rr_idle", bus.busy, 0);

        // reset mid-EXEC discards the write and restarts from ptr=0
        mon_en = 0;
        apply(2, LD, 8'h77);
        wait_gnt(c);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", bus.gnt, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_q", bus.q, 0);
        own_m = '0; own_vld_m = 1'b0;
        bus.req   = 4'b1001;
        bus.op    = {CLR, NOP, NOP, LD};
        bus.wdata = {8'h00, 8'h00, 8'h00, 8'h9C};
        @(negedge clk);
        check("mid_rst_q_hold", bus.q, 0);
        rst_n  = 1'b1;
        mon_en = 1;
        push_exp(4'b0001, 8'h9C, 0, LD);
        wait_gnt(c);
        check("post_rst_latency", c, 1);
        bus.req = '0;
        repeat (3) @(negedge clk);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
